seq_alu: RTL and testbench

SEQ_ALU -- requirements
Module: seq_alu

---
 rtl/seq_alu.sv | 131 +++++++++++++
 tb/tb_seq_alu.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_alu.sv
// Sequential ALU: one request at a time; shifts iterate one bit per cycle, other ops finish in one cycle.
// Latency 1 (k+1 for shifts by k>0); result held in DONE until out_ready, no new request accepted meanwhile.
module seq_alu #(
    parameter int DATA_W  = 64,
    parameter int SHAMT_W = 6
) (
    input  logic              clk,
    input  logic              arst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        alu_control,
    input  logic [DATA_W-1:0] operand_a,
    input  logic [DATA_W-1:0] operand_b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] alu_out,
    output logic              zero_flag,
    output logic              illegal_op
);

    localparam logic [3:0] OP_AND = 4'd0;
    localparam logic [3:0] OP_OR  = 4'd1;
    localparam logic [3:0] OP_ADD = 4'd2;
    localparam logic [3:0] OP_SLL = 4'd3;
    localparam logic [3:0] OP_SRL = 4'd4;
    localparam logic [3:0] OP_SUB = 4'd6;
    localparam logic [3:0] OP_SLT = 4'd7;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t              state, state_nxt;
    logic [DATA_W-1:0]   acc;
    logic [SHAMT_W-1:0]  cnt;
    logic                shift_left;

    logic                accept;
    logic                is_shift;
    logic                multi_cycle;
    logic                op_illegal;
    logic [SHAMT_W-1:0]  shamt;
    logic [DATA_W-1:0]   op_result;
    logic [DATA_W-1:0]   acc_shifted;

    always_comb begin
        accept      = in_valid && (state == IDLE);
        shamt       = operand_b[SHAMT_W-1:0];
        is_shift    = 1'b0;
        op_illegal  = 1'b0;
        op_result   = '0;
        case (alu_control)
            OP_AND: op_result = operand_a & operand_b;
            OP_OR:  op_result = operand_a | operand_b;
            OP_ADD: op_result = operand_a + operand_b;
            OP_SUB: op_result = operand_a - operand_b;
            OP_SLT: op_result = {{(DATA_W-1){1'b0}}, $signed(operand_a) < $signed(operand_b)};
            OP_SLL, OP_SRL: begin
                // A zero-length shift completes immediately with the unmodified operand.
                is_shift  = 1'b1;
                op_result = operand_a;
            end
            default: op_illegal = 1'b1;
        endcase
        multi_cycle = is_shift && (shamt != '0);
        acc_shifted = shift_left ? (acc << 1) : (acc >> 1);
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_nxt = multi_cycle ? SHIFT : DONE;
                end
            end
            SHIFT: begin
                if (cnt == SHAMT_W'(1)) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            acc        <= '0;
            cnt        <= '0;
            shift_left <= 1'b0;
            alu_out    <= '0;
            zero_flag  <= 1'b0;
            illegal_op <= 1'b0;
        end else if (accept) begin
            if (multi_cycle) begin
                acc        <= operand_a;
                cnt        <= shamt;
                shift_left <= (alu_control == OP_SLL);
            end else begin
                alu_out    <= op_result;
                zero_flag  <= (op_result == '0);
                illegal_op <= op_illegal;
            end
        end else if (state == SHIFT) begin
            acc <= acc_shifted;
            cnt <= cnt - SHAMT_W'(1);
            // The last shift step publishes the result directly, saving a cycle.
            if (cnt == SHAMT_W'(1)) begin
                alu_out    <= acc_shifted;
                zero_flag  <= (acc_shifted == '0);
                illegal_op <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_seq_alu.sv
// Scoreboard bench for seq_alu: expected results queued at issue, compared when the result appears.
module tb_seq_alu;

    localparam int DATA_W  = 64;
    localparam int SHAMT_W = 6;

    logic              clk;
    logic              arst;
    logic              in_valid;
    logic              in_ready;
    logic [3:0]        alu_control;
    logic [DATA_W-1:0] operand_a;
    logic [DATA_W-1:0] operand_b;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] alu_out;
    logic              zero_flag;
    logic              illegal_op;

    typedef struct {
        logic [DATA_W-1:0] d;
        logic              z;
        logic              il;
        int                lat;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    seq_alu #(.DATA_W(DATA_W), .SHAMT_W(SHAMT_W)) dut (
        .clk         (clk),
        .arst        (arst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .alu_control (alu_control),
        .operand_a   (operand_a),
        .operand_b   (operand_b),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .alu_out     (alu_out),
        .zero_flag   (zero_flag),
        .illegal_op  (illegal_op)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic exp_t model(input logic [3:0] c, input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
        exp_t e;
        int   k;
        k     = int'(b[SHAMT_W-1:0]);
        e.il  = 1'b0;
        e.lat = 1;
        case (c)
            4'd0: e.d = a & b;
            4'd1: e.d = a | b;
            4'd2: e.d = a + b;
            4'd3: begin e.d = a << k; if (k != 0) e.lat = k + 1; end
            4'd4: begin e.d = a >> k; if (k != 0) e.lat = k + 1; end
            4'd6: e.d = a - b;
            4'd7: e.d = ($signed(a) < $signed(b)) ? 64'd1 : 64'd0;
            default: begin e.d = '0; e.il = 1'b1; end
        endcase
        e.z = (e.d == '0);
        return e;
    endfunction

    // Issues one request with out_ready held high; returns what the DUT presented (lat = -1 on timeout).
    task automatic run_op(input logic [3:0] c, input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                          output int lat, output int low, output logic [DATA_W-1:0] d,
                          output logic z, output logic il);
        bit got;
        bit idle;
        exp_q.push_back(model(c, a, b));
        out_ready   = 1'b1;
        alu_control = c;
        operand_a   = a;
        operand_b   = b;
        in_valid    = 1'b1;
        @(posedge clk);
        #1;
        in_valid    = 1'b0;
        alu_control = 4'($urandom_range(15));
        operand_a   = {$urandom(), $urandom()};
        operand_b   = {$urandom(), $urandom()};
        got  = 1'b0;
        idle = 1'b0;
        lat  = -1;
        low  = -1;
        d    = '0;
        z    = 1'b0;
        il   = 1'b0;
        for (int i = 1; i <= 300; i++) begin
            @(negedge clk);
            if (out_valid && !got) begin
                got = 1'b1;
                lat = i;
                d   = alu_out;
                z   = zero_flag;
                il  = illegal_op;
            end
            if (in_ready) begin
                low  = i - 1;
                idle = 1'b1;
                break;
            end
        end
        if (!idle) lat = -1;
    endtask

    task automatic test_reset();
        arst        = 1'b0;
        in_valid    = 1'b0;
        out_ready   = 1'b0;
        alu_control = '0;
        operand_a   = '0;
        operand_b   = '0;
        #1 arst = 1'b1;
        #2;
        checks++;
        if ({in_ready, out_valid, alu_out, zero_flag, illegal_op} !== {1'b1, 1'b0, 64'd0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_outputs: rdy=%b vld=%b out=%h z=%b il=%b, want rdy=1 vld=0 out=0 z=0 il=0",
                     in_ready, out_valid, alu_out, zero_flag, illegal_op);
        end
        repeat (2) @(negedge clk);
        arst = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: rdy=%b vld=%b, want rdy=1 vld=0", in_ready, out_valid);
        end
        @(negedge clk);
    endtask

    task automatic test_add_wrap();
        int lat, low; logic [DATA_W-1:0] d; logic z, il; exp_t e;
        run_op(4'd2, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, lat, low, d, z, il);
        e = exp_q.pop_front();
        checks++;
        if (d !== e.d || z !== e.z || il !== e.il || lat !== e.lat || low !== 1) begin
            errors++;
            $display("FAIL add_wrap: out=%h z=%b il=%b lat=%0d busy=%0d, want out=%h z=%b il=%b lat=%0d busy=1",
                     d, z, il, lat, low, e.d, e.z, e.il, e.lat);
        end
    endtask

    task automatic test_arith();
        logic [3:0]        c_t [6] = '{4'd7, 4'd7, 4'd6, 4'd0, 4'd1, 4'd6};
        logic [DATA_W-1:0] a_t [6] = '{-64'sd5, 64'd3, 64'd10, 64'hF0F0, 64'h0F00, 64'd0};
        logic [DATA_W-1:0] b_t [6] = '{64'd3, -64'sd5, 64'd3, 64'hFF00, 64'h00F0, 64'd1};
        int lat, low; logic [DATA_W-1:0] d; logic z, il; exp_t e;
        for (int i = 0; i < 6; i++) begin
            run_op(c_t[i], a_t[i], b_t[i], lat, low, d, z, il);
            e = exp_q.pop_front();
            checks++;
            if (d !== e.d || z !== e.z || il !== e.il || lat !== e.lat) begin
                errors++;
                $display("FAIL arith_%0d op=%0d: out=%h z=%b il=%b lat=%0d, want out=%h z=%b il=%b lat=%0d",
                         i, c_t[i], d, z, il, lat, e.d, e.z, e.il, e.lat);
            end
        end
    endtask

    task automatic test_shift();
        logic [3:0]        c_t [5] = '{4'd3, 4'd4, 4'd4, 4'd3, 4'd4};
        logic [DATA_W-1:0] a_t [5] = '{64'd1, 64'h80, 64'h8000_0000_0000_0001, 64'hDEAD_BEEF, 64'h1};
        logic [DATA_W-1:0] b_t [5] = '{64'd63, 64'd0, 64'd3, 64'h104, 64'd1};
        int lat, low; logic [DATA_W-1:0] d; logic z, il; exp_t e;
        for (int i = 0; i < 5; i++) begin
            run_op(c_t[i], a_t[i], b_t[i], lat, low, d, z, il);
            e = exp_q.pop_front();
            checks++;
            if (d !== e.d || z !== e.z || il !== e.il || lat !== e.lat || low !== e.lat) begin
                errors++;
                $display("FAIL shift_%0d: out=%h z=%b il=%b lat=%0d busy=%0d, want out=%h z=%b il=%b lat=%0d busy=%0d",
                         i, d, z, il, lat, low, e.d, e.z, e.il, e.lat, e.lat);
            end
        end
    endtask

    task automatic test_illegal();
        logic [3:0]        c_t [4] = '{4'hF, 4'd2, 4'd5, 4'd3};
        logic [DATA_W-1:0] a_t [4] = '{64'h1234, 64'd1, 64'hFFFF, 64'h3};
        logic [DATA_W-1:0] b_t [4] = '{64'h5678, 64'd2, 64'h1, 64'd2};
        int lat, low; logic [DATA_W-1:0] d; logic z, il; exp_t e;
        for (int i = 0; i < 4; i++) begin
            run_op(c_t[i], a_t[i], b_t[i], lat, low, d, z, il);
            e = exp_q.pop_front();
            checks++;
            if (d !== e.d || z !== e.z || il !== e.il || lat !== e.lat) begin
                errors++;
                $display("FAIL illegal_%0d op=%0d: out=%h z=%b il=%b lat=%0d, want out=%h z=%b il=%b lat=%0d",
                         i, c_t[i], d, z, il, lat, e.d, e.z, e.il, e.lat);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [DATA_W-1:0] d; logic z, il; exp_t e; bit got;
        exp_q.push_back(model(4'd0, 64'hF0F0, 64'hFF00));
        out_ready   = 1'b0;
        alu_control = 4'd0;
        operand_a   = 64'hF0F0;
        operand_b   = 64'hFF00;
        in_valid    = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            got = out_valid;
        end
        d = alu_out; z = zero_flag; il = illegal_op;
        e = exp_q.pop_front();
        checks++;
        if (!got || d !== e.d || z !== e.z || il !== e.il) begin
            errors++;
            $display("FAIL bp_result: vld=%b out=%h z=%b il=%b, want vld=1 out=%h z=%b il=%b", got, d, z, il, e.d, e.z, e.il);
        end
        for (int i = 0; i < 5; i++) begin
            in_valid    = ~in_valid;
            alu_control = 4'($urandom_range(15));
            operand_a   = {$urandom(), $urandom()};
            operand_b   = {$urandom(), $urandom()};
            @(posedge clk);
            #1;
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || alu_out !== d || zero_flag !== z || illegal_op !== il) begin
                errors++;
                $display("FAIL bp_hold_%0d: vld=%b rdy=%b out=%h z=%b il=%b, want vld=1 rdy=0 out=%h z=%b il=%b",
                         i, out_valid, in_ready, alu_out, zero_flag, illegal_op, d, z, il);
            end
            @(negedge clk);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || alu_out !== d) begin
            errors++;
            $display("FAIL bp_release: rdy=%b vld=%b out=%h, want rdy=1 vld=0 out=%h", in_ready, out_valid, alu_out, d);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_abort();
        int lat, low, pulses; logic [DATA_W-1:0] d; logic z, il; exp_t e;
        exp_q.push_back(model(4'd4, 64'hFFFF_0000_FFFF_0000, 64'd40));
        out_ready   = 1'b1;
        alu_control = 4'd4;
        operand_a   = 64'hFFFF_0000_FFFF_0000;
        operand_b   = 64'd40;
        in_valid    = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (10) @(negedge clk);
        #1 arst = 1'b1;
        #1;
        checks++;
        if ({in_ready, out_valid, alu_out, zero_flag, illegal_op} !== {1'b1, 1'b0, 64'd0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL abort_immediate: rdy=%b vld=%b out=%h z=%b il=%b, want rdy=1 vld=0 out=0 z=0 il=0",
                     in_ready, out_valid, alu_out, zero_flag, illegal_op);
        end
        void'(exp_q.pop_front());
        repeat (2) @(negedge clk);
        arst   = 1'b0;
        pulses = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (out_valid) pulses++;
        end
        checks++;
        if (pulses !== 0) begin
            errors++;
            $display("FAIL abort_no_result: out_valid high for %0d cycles, want 0", pulses);
        end
        run_op(4'd2, 64'd5, 64'd6, lat, low, d, z, il);
        e = exp_q.pop_front();
        checks++;
        if (d !== e.d || z !== e.z || il !== e.il || lat !== e.lat) begin
            errors++;
            $display("FAIL abort_then_add: out=%h z=%b il=%b lat=%0d, want out=%h z=%b il=%b lat=%0d",
                     d, z, il, lat, e.d, e.z, e.il, e.lat);
        end
        checks++;
        if (exp_q.size() !== 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, want 0", exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_add_wrap();
        test_arith();
        test_shift();
        test_illegal();
        test_backpressure();
        test_reset_abort();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
